// File: rtl/bcd_time_keeper.sv
// 24-hour BCD time keeper with a validated valid/ready load path and an hour-derived colour code.
// Optional: define TIME_SECONDS_OUT_EN to expose the BCD seconds on time_out[31:24].
module bcd_time_keeper #(
  parameter int CLK_HZ     = 50000000,
  parameter int PRESCALE_W = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [23:0] load_data,
  output logic        load_ready,
  output logic        load_err,
  output logic [31:0] time_out,
  output logic        sec_pulse,
  output logic        min_strobe
);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY} state_t;

  localparam logic [PRESCALE_W-1:0] PRESCALE_TC = PRESCALE_W'(CLK_HZ - 1);

  state_t                state_reg, state_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [23:0]           shadow_reg, shadow_next;
  logic [3:0]            sec_u_reg, sec_u_next, sec_t_reg, sec_t_next;
  logic [3:0]            min_u_reg, min_u_next, min_t_reg, min_t_next;
  logic [3:0]            hr_u_reg, hr_u_next, hr_t_reg, hr_t_next;
  logic [1:0]            colour_reg, colour_next;
  logic                  load_err_reg, load_err_next;
  logic                  sec_pulse_reg, sec_pulse_next;
  logic                  min_strobe_reg, min_strobe_next;
  logic                  tick, min_carry, hr_carry;
  logic [7:0]            sec_byte;

  // BCD values order the same way as their binary counterparts, so direct compares work.
  function automatic logic load_ok(input logic [23:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (d[23:20] > 4'd2)   ok = 1'b0;
    if (d[23:16] > 8'h23)  ok = 1'b0;
    if (d[15:12] > 4'd5)   ok = 1'b0;
    if (d[7:4]   > 4'd5)   ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [1:0] colour_of(input logic [7:0] hr);
    logic [1:0] c;
    if (hr < 8'h06)      c = 2'd0;
    else if (hr < 8'h12) c = 2'd1;
    else if (hr < 8'h18) c = 2'd2;
    else                 c = 2'd3;
    return c;
  endfunction

  assign tick       = (prescale_reg == PRESCALE_TC);
  assign load_ready = (state_reg == IDLE);

  always_comb begin
    state_next      = state_reg;
    shadow_next     = shadow_reg;
    load_err_next   = 1'b0;
    sec_pulse_next  = 1'b0;
    min_strobe_next = 1'b0;
    prescale_next   = prescale_reg;
    sec_u_next      = sec_u_reg;
    sec_t_next      = sec_t_reg;
    min_u_next      = min_u_reg;
    min_t_next      = min_t_reg;
    hr_u_next       = hr_u_reg;
    hr_t_next       = hr_t_reg;
    colour_next     = colour_reg;
    min_carry       = 1'b0;
    hr_carry        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          shadow_next = load_data;
          state_next  = CHECK;
        end
      end
      CHECK: begin
        if (load_ok(shadow_reg)) begin
          state_next = APPLY;
        end else begin
          load_err_next = 1'b1;
          state_next    = IDLE;
        end
      end
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A load being applied swallows any coincident tick and restarts the second.
    if (state_reg == APPLY) begin
      prescale_next   = '0;
      hr_t_next       = shadow_reg[23:20];
      hr_u_next       = shadow_reg[19:16];
      min_t_next      = shadow_reg[15:12];
      min_u_next      = shadow_reg[11:8];
      sec_t_next      = shadow_reg[7:4];
      sec_u_next      = shadow_reg[3:0];
      colour_next     = colour_of(shadow_reg[23:16]);
      min_strobe_next = (shadow_reg[23:8] != {hr_t_reg, hr_u_reg, min_t_reg, min_u_reg});
    end else begin
      prescale_next = tick ? '0 : prescale_reg + PRESCALE_W'(1);
      if (tick) begin
        sec_pulse_next = 1'b1;
        if (sec_u_reg != 4'd9) begin
          sec_u_next = sec_u_reg + 4'd1;
        end else begin
          sec_u_next = 4'd0;
          if (sec_t_reg != 4'd5) begin
            sec_t_next = sec_t_reg + 4'd1;
          end else begin
            sec_t_next = 4'd0;
            min_carry  = 1'b1;
          end
        end

        if (min_carry) begin
          min_strobe_next = 1'b1;
          if (min_u_reg != 4'd9) begin
            min_u_next = min_u_reg + 4'd1;
          end else begin
            min_u_next = 4'd0;
            if (min_t_reg != 4'd5) begin
              min_t_next = min_t_reg + 4'd1;
            end else begin
              min_t_next = 4'd0;
              hr_carry   = 1'b1;
            end
          end
        end

        if (hr_carry) begin
          if ({hr_t_reg, hr_u_reg} == 8'h23) begin
            hr_t_next = 4'd0;
            hr_u_next = 4'd0;
          end else if (hr_u_reg == 4'd9) begin
            hr_u_next = 4'd0;
            hr_t_next = hr_t_reg + 4'd1;
          end else begin
            hr_u_next = hr_u_reg + 4'd1;
          end
          colour_next = colour_of({hr_t_next, hr_u_next});
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      prescale_reg   <= '0;
      shadow_reg     <= '0;
      sec_u_reg      <= '0;
      sec_t_reg      <= '0;
      min_u_reg      <= '0;
      min_t_reg      <= '0;
      hr_u_reg       <= '0;
      hr_t_reg       <= '0;
      colour_reg     <= '0;
      load_err_reg   <= 1'b0;
      sec_pulse_reg  <= 1'b0;
      min_strobe_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prescale_reg   <= prescale_next;
      shadow_reg     <= shadow_next;
      sec_u_reg      <= sec_u_next;
      sec_t_reg      <= sec_t_next;
      min_u_reg      <= min_u_next;
      min_t_reg      <= min_t_next;
      hr_u_reg       <= hr_u_next;
      hr_t_reg       <= hr_t_next;
      colour_reg     <= colour_next;
      load_err_reg   <= load_err_next;
      sec_pulse_reg  <= sec_pulse_next;
      min_strobe_reg <= min_strobe_next;
    end
  end

`ifdef TIME_SECONDS_OUT_EN
  assign sec_byte = {sec_t_reg, sec_u_reg};
`else
  assign sec_byte = 8'h00;
`endif

  assign time_out   = {sec_byte, 6'b0, colour_reg, hr_t_reg, hr_u_reg, min_t_reg, min_u_reg};
  assign load_err   = load_err_reg;
  assign sec_pulse  = sec_pulse_reg;
  assign min_strobe = min_strobe_reg;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper with a 10-cycle second: load vector table plus tick/reset sequences.
module tb_bcd_time_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [23:0] load_data;
  logic        load_ready;
  logic        load_err;
  logic [31:0] time_out;
  logic        sec_pulse;
  logic        min_strobe;

  int vectors = 0;
  int miscompares = 0;

  bcd_time_keeper #(.CLK_HZ(10), .PRESCALE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_err   (load_err),
    .time_out   (time_out),
    .sec_pulse  (sec_pulse),
    .min_strobe (min_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        exp_err;
    logic        exp_strobe;
    logic [31:0] exp_time;
  } vec_t;

  vec_t vecs[14];

  // Seconds byte as it should appear on time_out[31:24] in this build.
  function automatic logic [31:0] sb(input logic [7:0] s);
`ifdef TIME_SECONDS_OUT_EN
    return {s, 24'h0};
`else
    return 32'h0 & {24'h0, s};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    load_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Presents one load; returns just after the handshake edge with the inputs scrambled.
  task automatic do_load(input logic [23:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
    load_data  = 24'hFFFFFF;
  endtask

  initial begin
    int sp_cnt, ms_cnt;
    reset = 1'b1;
    load_valid = 1'b0;
    load_data = 24'h0;

    vecs[0]  = '{24'h125958, 1'b0, 1'b1, 32'h00021259 | sb(8'h58)};
    vecs[1]  = '{24'h235959, 1'b0, 1'b1, 32'h00032359 | sb(8'h59)};
    vecs[2]  = '{24'h051230, 1'b0, 1'b1, 32'h00000512 | sb(8'h30)};
    vecs[3]  = '{24'h000000, 1'b0, 1'b0, 32'h00000000};
    vecs[4]  = '{24'h065900, 1'b0, 1'b1, 32'h00010659};
    vecs[5]  = '{24'h180000, 1'b0, 1'b1, 32'h00031800};
    vecs[6]  = '{24'h115959, 1'b0, 1'b1, 32'h00011159 | sb(8'h59)};
    vecs[7]  = '{24'h000045, 1'b0, 1'b0, sb(8'h45)};
    vecs[8]  = '{24'h245900, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{24'h1A0000, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{24'h006000, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{24'h000060, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{24'h300000, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{24'h005A00, 1'b1, 1'b0, 32'h0};

    // Reset state, then the first free-running second.
    reset_dut();
    chk("rst_time", time_out, 32'h0);
    chk("rst_ready", {31'h0, load_ready}, 32'h1);
    chk("rst_pulses", {29'h0, load_err, sec_pulse, min_strobe}, 32'h0);
    sp_cnt = 0;
    repeat (9) begin step(); sp_cnt += int'(sec_pulse); end
    chk("first_sec_quiet", sp_cnt, 0);
    step();
    chk("first_sec_pulse", {31'h0, sec_pulse}, 32'h1);
    chk("first_sec_time", time_out, sb(8'h01));

    // Load table: each from reset, so no tick lands inside the transfer.
    foreach (vecs[i]) begin
      reset_dut();
      do_load(vecs[i].data);
      chk($sformatf("v%0d_ready_n", i), {31'h0, load_ready}, 32'h0);
      step();
      chk($sformatf("v%0d_err", i), {31'h0, load_err}, {31'h0, vecs[i].exp_err});
      step();
      chk($sformatf("v%0d_time", i), time_out, vecs[i].exp_time);
      chk($sformatf("v%0d_strobe", i), {31'h0, min_strobe}, {31'h0, vecs[i].exp_strobe});
      chk($sformatf("v%0d_ready_err", i), {30'h0, load_ready, load_err}, 32'h2);
    end

    // 12:59:58 + two seconds -> 13:00, exactly one minute strobe, colour stays 2.
    reset_dut();
    do_load(24'h125958);
    repeat (2) step();
    sp_cnt = 0; ms_cnt = 0;
    repeat (9) begin step(); sp_cnt += int'(sec_pulse); ms_cnt += int'(min_strobe); end
    chk("roll_prescale_restart", sp_cnt, 0);
    step();
    chk("roll_sec1_pulse", {31'h0, sec_pulse}, 32'h1);
    chk("roll_sec1_time", time_out, 32'h00021259 | sb(8'h59));
    ms_cnt += int'(min_strobe);
    repeat (10) begin step(); ms_cnt += int'(min_strobe); end
    chk("roll_sec2_time", time_out, 32'h00021300);
    chk("roll_sec2_strobe", {31'h0, min_strobe}, 32'h1);
    chk("roll_strobe_count", ms_cnt, 1);

    // Midnight wrap.
    reset_dut();
    do_load(24'h235959);
    repeat (2) step();
    repeat (10) step();
    chk("midnight_time", time_out, 32'h0);
    chk("midnight_pulses", {30'h0, sec_pulse, min_strobe}, 32'h3);

    // APPLY coincides with the tick at edge 10: load wins, next tick 10 cycles later.
    reset_dut();
    repeat (7) step();
    do_load(24'h101010);
    repeat (2) step();
    chk("apply_tick_time", time_out, 32'h00011010 | sb(8'h10));
    chk("apply_tick_no_pulse", {31'h0, sec_pulse}, 32'h0);
    sp_cnt = 0;
    repeat (9) begin step(); sp_cnt += int'(sec_pulse); end
    chk("apply_tick_quiet", sp_cnt, 0);
    step();
    chk("apply_tick_next_pulse", {31'h0, sec_pulse}, 32'h1);
    chk("apply_tick_next_time", time_out, 32'h00011010 | sb(8'h11));

    // Reset during CHECK of a valid load.
    reset_dut();
    do_load(24'h235959);
    repeat (2) step();
    do_load(24'h125958);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_check_time", time_out, 32'h0);
    chk("rst_check_ready_err", {30'h0, load_ready, load_err}, 32'h2);
    ms_cnt = 0;
    repeat (3) begin step(); ms_cnt += int'(load_err); end
    chk("rst_check_no_err", ms_cnt, 0);
    chk("rst_check_time_after", time_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_time_keeper.md
Name: bcd_time_keeper

Overview:
- Upstream stage that produces the 32-bit packed BCD time word consumed by the clock display and servo stage.
- Free-runs a local 24-hour BCD clock from the 50 MHz system clock.
- Accepts validated time loads from the HPS bridge through a valid/ready handshake.
- Derives the 2-bit RGB colour code from the hour.

Parameters:
- CLK_HZ, 50000000, system clock cycles per second; the prescaler terminal count is CLK_HZ-1.
- PRESCALE_W, 26, prescaler counter width; must satisfy 2^PRESCALE_W > CLK_HZ.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous reset, active-high.
- load_valid  in  1  HPS load request; held high until accepted.
- load_data  in  24  BCD hh:mm:ss: [23:20] hour tens, [19:16] hour units, [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
- load_ready  out  1  high only in IDLE; a transfer occurs when load_valid & load_ready.
- load_err  out  1  one-cycle pulse when a captured load fails validation.
- time_out  out  32  packed word: [3:0] min units, [7:4] min tens, [11:8] hour units, [15:12] hour tens, [17:16] colour code, [23:18] zero, [31:24] see Optional Feature.
- sec_pulse  out  1  one-cycle pulse on every seconds increment.
- min_strobe  out  1  one-cycle pulse when the minutes field changes (increment or applied load).

Behaviour:
- Reset, synchronous, takes priority over everything:
  - time fields = 00:00:00, prescaler = 0, FSM = IDLE.
  - load_ready = 1, load_err = 0, sec_pulse = 0, min_strobe = 0.
  - time_out = 32'h0 (colour code 0).
- Prescaler:
  - Counts 0..CLK_HZ-1.
  - At terminal count it wraps to 0 and asserts tick for one cycle.
  - The increment is registered at that edge; sec_pulse is high in the same cycle that the new seconds value is visible.
- BCD increment chain:
  - Seconds units 0-9 carry into tens 0-5; 59 -> 00 carries into minutes.
  - Minutes use the same rule; a carry into hours, or any minutes change, asserts min_strobe.
  - Hours count 00..23; 23:59:59 -> 00:00:00 with no further carry.
- Colour code from hour: 00-05 -> 0; 06-11 -> 1; 12-17 -> 2; 18-23 -> 3. Updated in the same cycle as the hour fields.
- FSM states and transitions:
  - IDLE: on load_valid & load_ready, capture load_data into a shadow register and go to CHECK. load_ready is 0 in every state other than IDLE.
  - CHECK:
    - Validation requires all nibbles <= 9, hour tens <= 2, hour <= 23, minute tens <= 5, second tens <= 5.
    - Pass -> APPLY.
    - Fail -> pulse load_err, return to IDLE; time unchanged.
  - APPLY:
    - Write the shadow register to the time fields and clear the prescaler to 0.
    - Pulse min_strobe if the minutes or hours differ from the current value.
    - Return to IDLE.
- Latency: handshake at edge N, check at N+1, new time visible on time_out after edge N+2. load_ready is high again after N+2.
- Simultaneous events:
  - Prescaler tick in the APPLY cycle: the load wins, the tick is discarded, no sec_pulse.
  - Tick during CHECK: the increment proceeds normally; APPLY then overwrites it.
- Reset mid-load: the shadow register is discarded, FSM = IDLE, no load_err.
- load_data is sampled only at the handshake; changes afterwards are ignored.

Optional Feature:
- Macro: TIME_SECONDS_OUT_EN.
- Defined: time_out[31:24] = {sec tens, sec units} BCD, updated with the seconds fields.
- Undefined: time_out[31:24] is constant 0, and the seconds registers remain internal (still counted and still loadable).

Test Plan:
- Reset: assert reset 3 cycles with CLK_HZ=10 -> time_out=32'h0, load_ready=1, no pulses.
- Load 0x125958 with CLK_HZ=10 -> time_out[15:0]=16'h1259 and [17:16]=2 at N+2. After 2 ticks: time_out[15:0]=16'h1300, min_strobe once, colour code stays 2.
- Load 0x235959 then one tick -> time_out=32'h0; sec_pulse and min_strobe high in the same cycle.
- Invalid loads 0x245900 and 0x1A0000 -> load_err pulse each, time_out unchanged, load_ready back high 2 cycles after each handshake.
- Load handshake aligned so APPLY coincides with a tick -> loaded value exact, no sec_pulse, prescaler restarts (next tick exactly CLK_HZ cycles later).
- Reset asserted during CHECK of a valid load -> time_out=32'h0, no load_err. With TIME_SECONDS_OUT_EN, load 0x051230 -> time_out[31:24]=8'h30, colour code 0.
